// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin arbiter sharing one registered ripple-carry add/sub datapath
// between two valid/ready requesters, returning tagged results on one channel.
module adder_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic             req0_sub_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic             req1_sub_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             res_id_o,
  output logic [WIDTH-1:0] res_sum_o,
  output logic             res_carry_o,
  output logic             res_ovf_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] op_count_o
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t           r_state;
  logic             r_last;
  logic             r_sub;
  logic             r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             w_g0;
  logic             w_g1;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_c;
  // On contention the requester that was not served last wins.
  assign w_g0 = req0_valid_i && (!req1_valid_i || r_last);
  assign w_g1 = req1_valid_i && (!req0_valid_i || !r_last);
  assign req0_ready_o = !rst_i && r_state == IDLE && w_g0;
  assign req1_ready_o = !rst_i && r_state == IDLE && w_g1;
  assign busy_o = r_state != IDLE;
  assign w_b = r_sub ? ~r_b : r_b;
  assign w_c[0] = r_sub;
  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    assign w_sum[i]   = r_a[i] ^ w_b[i] ^ w_c[i];
    assign w_c[i+1]   = (r_a[i] & w_b[i]) | (w_c[i] & (r_a[i] ^ w_b[i]));
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_sub       <= 1'b0;
      r_id        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      res_valid_o <= 1'b0;
      res_id_o    <= 1'b0;
      res_sum_o   <= '0;
      res_carry_o <= 1'b0;
      res_ovf_o   <= 1'b0;
      op_count_o  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_g0 || w_g1) begin
          r_a     <= w_g1 ? req1_a_i : req0_a_i;
          r_b     <= w_g1 ? req1_b_i : req0_b_i;
          r_sub   <= w_g1 ? req1_sub_i : req0_sub_i;
          r_id    <= w_g1;
          r_last  <= w_g1;
          r_state <= EXEC;
        end
        EXEC: begin
          res_sum_o   <= w_sum;
          res_carry_o <= w_c[WIDTH];
          res_ovf_o   <= (r_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
          res_id_o    <= r_id;
          res_valid_o <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: if (res_ready_i) begin
          res_valid_o <= 1'b0;
          op_count_o  <= op_count_o + CNT_W'(1);
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: randomized scenarios checked against an arithmetic model of the
// shared add/sub arbiter (round-robin grant, 33-bit unsigned and 64-bit signed views).
module tb_adder_share_arbiter;
  logic        clk = 0;
  logic        rst_i = 1;
  logic        req0_valid_i = 0, req1_valid_i = 0;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_a_i = 0, req0_b_i = 0, req1_a_i = 0, req1_b_i = 0;
  logic        req0_sub_i = 0, req1_sub_i = 0;
  logic        res_valid_o, res_ready_i = 0, res_id_o;
  logic [31:0] res_sum_o;
  logic        res_carry_o, res_ovf_o, busy_o;
  logic [3:0]  op_count_o;
  int          n_checks = 0, n_fail = 0;
  bit          m_last = 1;
  int          m_count = 0;

  adder_share_arbiter #(.WIDTH(32), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_sub_i(req0_sub_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_sub_i(req1_sub_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_id_o(res_id_o),
    .res_sum_o(res_sum_o), .res_carry_o(res_carry_o), .res_ovf_o(res_ovf_o),
    .busy_o(busy_o), .op_count_o(op_count_o)
  );

  always #5 clk = ~clk;

  // Returns {carry, sum, ovf}: carry from 33-bit unsigned math, ovf from exact signed math.
  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b, input bit sub);
    longint sa, sb, r;
    logic [32:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    u = sub ? {1'b0, a} + {1'b0, ~b} + 33'd1 : {1'b0, a} + {1'b0, b};
    r = sub ? sa - sb : sa + sb;
    return {u[32], u[31:0], (r > 64'sd2147483647 || r < -64'sd2147483648)};
  endfunction

  task automatic transact(input int hold, input bit keep);
    bit g;
    logic [33:0] e;
    #1;
    g = (req0_valid_i && req1_valid_i) ? !m_last : req1_valid_i;
    n_checks++;
    if ({req0_ready_o, req1_ready_o} !== {~g, g}) begin
      n_fail++;
      $display("FAIL grant: got r0r1=%b expected %b", {req0_ready_o, req1_ready_o}, {~g, g});
    end
    e = g ? ref_op(req1_a_i, req1_b_i, req1_sub_i) : ref_op(req0_a_i, req0_b_i, req0_sub_i);
    m_last = g;
    @(negedge clk);
    if (!keep) begin
      if (g) req1_valid_i = 0;
      else req0_valid_i = 0;
    end
    n_checks++;
    if ({busy_o, res_valid_o, req0_ready_o, req1_ready_o} !== 4'b1000) begin
      n_fail++;
      $display("FAIL exec_state: got busy/valid/r0/r1=%b expected 1000",
               {busy_o, res_valid_o, req0_ready_o, req1_ready_o});
    end
    @(negedge clk);
    for (int k = 0; k <= hold; k++) begin
      res_ready_i = (k == hold);
      n_checks++;
      if ({res_valid_o, res_id_o, res_carry_o, res_sum_o, res_ovf_o, busy_o, req0_ready_o, req1_ready_o}
          !== {1'b1, g, e, 1'b1, 2'b00}) begin
        n_fail++;
        $display("FAIL result_hold[%0d]: got v=%b id=%b c=%b sum=%h o=%b busy=%b rdy=%b%b expected id=%b c=%b sum=%h o=%b",
                 k, res_valid_o, res_id_o, res_carry_o, res_sum_o, res_ovf_o, busy_o, req0_ready_o, req1_ready_o,
                 g, e[33], e[32:1], e[0]);
      end
      if (k < hold) @(negedge clk);
    end
    @(negedge clk);
    res_ready_i = 0;
    m_count++;
    n_checks++;
    if ({res_valid_o, busy_o, op_count_o, res_id_o, res_carry_o, res_sum_o, res_ovf_o}
        !== {2'b00, 4'(m_count), g, e}) begin
      n_fail++;
      $display("FAIL handshake: got v=%b busy=%b cnt=%0d id=%b sum=%h expected v=0 busy=0 cnt=%0d id=%b sum=%h",
               res_valid_o, busy_o, op_count_o, res_id_o, res_sum_o, 4'(m_count), g, e[32:1]);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_i = 1; req0_valid_i = 1; req1_valid_i = 1; res_ready_i = 1;
    req0_a_i = $urandom; req1_a_i = $urandom;
    @(negedge clk);
    n_checks++;
    if ({req0_ready_o, req1_ready_o, res_valid_o, res_id_o, res_sum_o, res_carry_o, res_ovf_o, busy_o, op_count_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b%b v=%b sum=%h busy=%b cnt=%0d expected all 0",
               req0_ready_o, req1_ready_o, res_valid_o, res_sum_o, busy_o, op_count_o);
    end
    rst_i = 0; req0_valid_i = 0; req1_valid_i = 0; res_ready_i = 0;
    m_last = 1; m_count = 0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    req0_valid_i = 1; req0_a_i = 32'h1; req0_b_i = 32'h1; req0_sub_i = 0;
    transact(0, 0);
    n_checks++;
    if ({res_id_o, res_sum_o, res_carry_o, res_ovf_o, op_count_o} !== {1'b0, 32'h2, 2'b00, 4'd1}) begin
      n_fail++;
      $display("FAIL basic_add: got id=%b sum=%h c=%b o=%b cnt=%0d expected 0 00000002 0 0 1",
               res_id_o, res_sum_o, res_carry_o, res_ovf_o, op_count_o);
    end
    req1_valid_i = 1; req1_a_i = 32'hFFFFFFFF; req1_b_i = 32'h1; req1_sub_i = 0;
    transact(0, 0);
    n_checks++;
    if ({res_id_o, res_sum_o, res_carry_o, res_ovf_o} !== {1'b1, 32'h0, 2'b10}) begin
      n_fail++;
      $display("FAIL carry_add: got id=%b sum=%h c=%b o=%b expected 1 00000000 1 0",
               res_id_o, res_sum_o, res_carry_o, res_ovf_o);
    end
  endtask

  task automatic test_contention;
    req0_valid_i = 1; req0_a_i = 32'h7FFFFFFF; req0_b_i = 32'hFFFFFFFF; req0_sub_i = 1;
    req1_valid_i = 1; req1_a_i = 32'h12345678; req1_b_i = 32'h87654321; req1_sub_i = 0;
    transact(0, 1);
    n_checks++;
    if ({res_id_o, res_sum_o, res_carry_o, res_ovf_o} !== {1'b0, 32'h80000000, 2'b01}) begin
      n_fail++;
      $display("FAIL contend_first: got id=%b sum=%h c=%b o=%b expected 0 80000000 0 1",
               res_id_o, res_sum_o, res_carry_o, res_ovf_o);
    end
    transact(0, 1);
    n_checks++;
    if ({res_id_o, res_sum_o, res_carry_o, res_ovf_o} !== {1'b1, 32'h99999999, 2'b00}) begin
      n_fail++;
      $display("FAIL contend_second: got id=%b sum=%h c=%b o=%b expected 1 99999999 0 0",
               res_id_o, res_sum_o, res_carry_o, res_ovf_o);
    end
    transact(0, 1);
    n_checks++;
    if (res_id_o !== 1'b0) begin
      n_fail++;
      $display("FAIL alternation: got id=%b expected 0", res_id_o);
    end
    req0_valid_i = 0; req1_valid_i = 0;
  endtask

  task automatic test_backpressure;
    req0_valid_i = 1; req0_a_i = $urandom; req0_b_i = $urandom; req0_sub_i = 1'($urandom);
    req1_valid_i = 1; req1_a_i = $urandom; req1_b_i = $urandom; req1_sub_i = 1'($urandom);
    transact(5, 1);
    transact(0, 1);
    req0_valid_i = 0; req1_valid_i = 0;
  endtask

  task automatic test_async_reset;
    req0_valid_i = 1; req0_a_i = $urandom; req0_b_i = $urandom; req0_sub_i = 0;
    @(posedge clk);
    #2 rst_i = 1;
    #1;
    n_checks++;
    if ({req0_ready_o, req1_ready_o, res_valid_o, res_id_o, res_sum_o, res_carry_o, res_ovf_o, busy_o, op_count_o} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got rdy=%b%b v=%b sum=%h busy=%b cnt=%0d expected all 0",
               req0_ready_o, req1_ready_o, res_valid_o, res_sum_o, busy_o, op_count_o);
    end
    @(negedge clk);
    rst_i = 0; req0_valid_i = 0;
    m_last = 1; m_count = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if ({res_valid_o, busy_o, op_count_o} !== 6'b0) begin
        n_fail++;
        $display("FAIL aborted_op[%0d]: got v=%b busy=%b cnt=%0d expected 0 0 0", k, res_valid_o, busy_o, op_count_o);
      end
    end
  endtask

  task automatic test_random_wrap;
    for (int n = 1; n <= 30; n++) begin
      int pat;
      pat = $urandom_range(1, 3);
      req0_valid_i = pat[0]; req1_valid_i = pat[1];
      req0_a_i = $urandom; req0_b_i = $urandom; req0_sub_i = 1'($urandom);
      req1_a_i = $urandom; req1_b_i = $urandom; req1_sub_i = 1'($urandom);
      if (n % 4 == 0) begin req0_b_i = req0_a_i; req1_b_i = 32'h80000000; end
      transact($urandom_range(0, 2), 1'($urandom));
      if (n == 16 || n == 17) begin
        n_checks++;
        if (op_count_o !== 4'(n - 16)) begin
          n_fail++;
          $display("FAIL count_wrap: got %0d after %0d ops expected %0d", op_count_o, n, n - 16);
        end
      end
    end
    req0_valid_i = 0; req1_valid_i = 0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_reset;
    test_contention;
    test_backpressure;
    test_async_reset;
    test_random_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one 32-bit add/subtract datapath (the team's ripple_carry_adder) between two independent requesters.
- Requests are taken with a valid/ready handshake and arbitrated round-robin.
- Each granted operation runs on registered operands. The sum, carry and signed overflow are returned on a single result channel tagged with the requester ID.
- Sits between the two client blocks and the shared adder, so neither client drives the adder directly.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- req0_valid_i  input  1  requester 0 has an operation pending.
- req0_ready_o  output  1  requester 0 operation accepted this cycle.
- req0_a_i  input  WIDTH  requester 0 operand A.
- req0_b_i  input  WIDTH  requester 0 operand B.
- req0_sub_i  input  1  requester 0 op select: 0 = A+B, 1 = A-B.
- req1_valid_i, req1_ready_o, req1_a_i, req1_b_i, req1_sub_i: same as requester 0, for requester 1.
- res_valid_o  output  1  result registers hold a valid result.
- res_ready_i  input  1  consumer accepts the result.
- res_id_o  output  1  requester that owns the result.
- res_sum_o  output  WIDTH  sum/difference.
- res_carry_o  output  1  carry out of bit WIDTH-1.
- res_ovf_o  output  1  two's-complement signed overflow.
- busy_o  output  1  high in any state other than IDLE.
- op_count_o  output  CNT_W  number of completed result handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is asynchronous and active-high.
- While rst_i is high:
  - all outputs are 0;
  - state = IDLE;
  - last_grant = 1, so requester 0 wins the first contention;
  - op_count = 0;
  - operand registers = 0.
- Reset asserted mid-operation discards the in-flight op. No result is produced for it after release.
- FSM IDLE:
  - reqN_ready_o is combinational, high only in IDLE and only for the granted requester.
  - With exactly one valid requester, grant it.
  - With both valid, grant the one != last_grant.
  - On grant: latch A, B, sub and id; update last_grant; go to EXEC.
  - With no valid requester, stay in IDLE.
- FSM EXEC (1 cycle):
  - The adder evaluates the registered operands.
  - Add: {carry,sum} = A + B.
  - Sub: {carry,sum} = A + ~B + 1, so carry = 1 means no borrow.
  - ovf = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]), where B' = B for add and ~B for sub.
  - Register sum, carry, ovf and id; set res_valid_o = 1; go to HOLD.
- FSM HOLD:
  - res_* are stable while res_valid_o && !res_ready_i.
  - On res_ready_i = 1: clear res_valid_o, increment op_count, go to IDLE.
  - res_* data outputs keep their last values after res_valid_o clears.
- Timing and throughput:
  - Latency: accept at edge k → res_valid_o high after edge k+1.
  - Best-case throughput: one op per 3 cycles.
  - Requests are not accepted during EXEC or HOLD; reqN_ready_o = 0 there.
- Requesters must hold valid and operands stable until ready; a dropped valid before grant is simply not serviced.
- Carry and overflow are unsigned and signed views of the same WIDTH-bit operation; no sticky flags.

Test Plan:
- Reset, then req0 add 0x00000001 + 0x00000001 → req0_ready_o pulses once; 2 cycles later res_valid_o=1, id=0, sum=0x00000002, carry=0, ovf=0; with res_ready_i=1, op_count=1.
- req1 add 0xFFFFFFFF + 0x00000001 → id=1, sum=0x00000000, carry=1, ovf=0.
- Both valid after reset: req0 sub 0x7FFFFFFF - 0xFFFFFFFF; req1 add 0x12345678 + 0x87654321.
  - First result: id=0, sum=0x80000000, carry=0, ovf=1.
  - Second result: id=1, sum=0x99999999, carry=0, ovf=0.
  - Both held valid again → req0 granted next (alternation).
- Backpressure: hold res_ready_i=0 for 5 cycles with both requesters valid → res_* stable, both req ready low, busy_o=1; release → one handshake, then the next grant.
- Assert rst_i asynchronously (between clock edges) during EXEC → all outputs 0 immediately, without waiting for the next clock edge; after release no res_valid_o for the aborted op; op_count=0.
- CNT_W=4, 16 completed ops → op_count_o wraps to 0; the 17th completed op gives 1.
